// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, taken-branch and I/D-cache miss control.
// Optional performance counters are built when STALL_CNT_EN is defined.
module pipe_stall_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [4:0]       i_id_rs,
  input  logic [4:0]       i_id_rt,
  input  logic             i_ex_mem_read,
  input  logic [4:0]       i_ex_rt,
  input  logic             i_br_taken,
  input  logic             i_ic_miss,
  input  logic             i_ic_ready,
  input  logic             i_dc_miss,
  input  logic             i_dc_ready,
  output logic             o_pc_we,
  output logic             o_if_id_we,
  output logic             o_if_id_zero,
  output logic             o_id_ex_zero,
  output logic             o_ex_mem_we,
  output logic             o_mem_wb_we,
  output logic             o_err,
  output logic [CNT_W-1:0] o_stall_cyc,
  output logic [CNT_W-1:0] o_flush_cnt
);

  localparam int TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  // The timeout fires on the TIMEOUT-th cycle spent in a wait state.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_RUN, S_IWAIT, S_DWAIT} state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic             r_ic_pend;
  logic             w_ic_pend_next;
  logic [TMO_W-1:0] r_tmo;
  logic             r_err;
  logic             w_timeout;
  logic             w_load_use;

  assign w_load_use = i_ex_mem_read && (i_ex_rt != 5'd0) &&
                      ((i_ex_rt == i_id_rs) || (i_ex_rt == i_id_rt));

  always_comb begin
    o_pc_we      = 1'b1;
    o_if_id_we   = 1'b1;
    o_if_id_zero = 1'b0;
    o_id_ex_zero = 1'b0;
    o_ex_mem_we  = 1'b1;
    o_mem_wb_we  = 1'b1;
    if (i_rst) begin
      o_pc_we      = 1'b0;
      o_if_id_we   = 1'b0;
      o_if_id_zero = 1'b1;
      o_id_ex_zero = 1'b1;
      o_ex_mem_we  = 1'b0;
      o_mem_wb_we  = 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (i_dc_miss) begin
            o_pc_we     = 1'b0;
            o_if_id_we  = 1'b0;
            o_ex_mem_we = 1'b0;
            o_mem_wb_we = 1'b0;
          end else if (i_ic_miss) begin
            o_pc_we      = 1'b0;
            o_if_id_zero = 1'b1;
          end else if (w_load_use) begin
            o_pc_we      = 1'b0;
            o_if_id_we   = 1'b0;
            o_id_ex_zero = 1'b1;
          end else if (i_br_taken) begin
            o_if_id_zero = 1'b1;
          end
        end
        S_IWAIT: begin
          // Keep feeding NOPs into ID while the fetch is outstanding; a load-use still holds ID.
          o_pc_we      = 1'b0;
          o_if_id_zero = 1'b1;
          if (w_load_use) begin
            o_if_id_we   = 1'b0;
            o_id_ex_zero = 1'b1;
          end
        end
        S_DWAIT: begin
          o_pc_we     = 1'b0;
          o_if_id_we  = 1'b0;
          o_ex_mem_we = 1'b0;
          o_mem_wb_we = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next_state   = r_state;
    w_ic_pend_next = r_ic_pend;
    w_timeout      = 1'b0;
    case (r_state)
      S_RUN: begin
        if (i_dc_miss) begin
          w_next_state   = S_DWAIT;
          w_ic_pend_next = i_ic_miss;
        end else if (i_ic_miss) begin
          w_next_state = S_IWAIT;
        end
      end
      S_IWAIT: begin
        if (i_dc_miss) begin
          w_next_state   = S_DWAIT;
          w_ic_pend_next = !i_ic_ready;
        end else if (i_ic_ready) begin
          w_next_state = S_RUN;
        end
      end
      S_DWAIT: begin
        if (i_ic_ready) w_ic_pend_next = 1'b0;
        if (i_dc_ready) begin
          w_next_state   = (r_ic_pend && !i_ic_ready) ? S_IWAIT : S_RUN;
          w_ic_pend_next = 1'b0;
        end
      end
      default: w_next_state = S_RUN;
    endcase
    if ((r_state != S_RUN) && (r_tmo == TMO_LAST)) begin
      w_next_state   = S_RUN;
      w_ic_pend_next = 1'b0;
      w_timeout      = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_RUN;
      r_ic_pend <= 1'b0;
      r_tmo     <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_ic_pend <= w_ic_pend_next;
      r_err     <= r_err | w_timeout;
      if ((w_next_state != r_state) || (r_state == S_RUN))
        r_tmo <= '0;
      else
        r_tmo <= r_tmo + 1'b1;
    end
  end

  assign o_err = r_err;

`ifdef STALL_CNT_EN
  logic [CNT_W-1:0] r_stall_cyc;
  logic [CNT_W-1:0] r_flush_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stall_cyc <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!o_pc_we)     r_stall_cyc <= r_stall_cyc + 1'b1;
      if (o_if_id_zero) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign o_stall_cyc = r_stall_cyc;
  assign o_flush_cnt = r_flush_cnt;
`else
  assign o_stall_cyc = '0;
  assign o_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: directed vectors push expected controls, a negedge monitor checks them.
module tb_pipe_stall_ctrl;
  localparam int CNT_W = 32;

  // Expected vector layout: {pc_we, if_id_we, if_id_zero, id_ex_zero, ex_mem_we, mem_wb_we, err}
  localparam logic [6:0] RST   = 7'b0011000;
  localparam logic [6:0] NORM  = 7'b1100110;
  localparam logic [6:0] LU    = 7'b0001110;
  localparam logic [6:0] BR    = 7'b1110110;
  localparam logic [6:0] IMISS = 7'b0110110;
  localparam logic [6:0] IWLU  = 7'b0011110;
  localparam logic [6:0] FRZ   = 7'b0000000;
  localparam logic [6:0] ERR   = 7'b0000001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] idRs = '0, idRt = '0, exRt = '0;
  logic exMemRead = 1'b0, brTaken = 1'b0, icMiss = 1'b0, icReady = 1'b0, dcMiss = 1'b0, dcReady = 1'b0;
  logic pcWe, ifIdWe, ifIdZero, idExZero, exMemWe, memWbWe, err;
  logic [CNT_W-1:0] stallCyc, flushCnt;

  typedef struct packed {
    logic       r;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       exRd;
    logic [4:0] exRt;
    logic       br;
    logic       icm;
    logic       icr;
    logic       dcm;
    logic       dcr;
    logic [6:0] exp;
  } vec_t;

  vec_t  stimQ[$];
  string stimNameQ[$];
  logic [6:0] expQ[$];
  string nameQ[$];

  int vecCount = 0;
  int missCount = 0;
  int expStall = 0;
  int expFlush = 0;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.TIMEOUT(255), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_id_rs(idRs), .i_id_rt(idRt),
    .i_ex_mem_read(exMemRead), .i_ex_rt(exRt), .i_br_taken(brTaken),
    .i_ic_miss(icMiss), .i_ic_ready(icReady), .i_dc_miss(dcMiss), .i_dc_ready(dcReady),
    .o_pc_we(pcWe), .o_if_id_we(ifIdWe), .o_if_id_zero(ifIdZero), .o_id_ex_zero(idExZero),
    .o_ex_mem_we(exMemWe), .o_mem_wb_we(memWbWe), .o_err(err),
    .o_stall_cyc(stallCyc), .o_flush_cnt(flushCnt)
  );

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %b required %b", nm, act, exp);
    end
  endtask

  task automatic addVec(input logic r, input logic [4:0] rs, input logic [4:0] rt, input logic exRd,
                        input logic [4:0] eRt, input logic br, input logic icm, input logic icr,
                        input logic dcm, input logic dcr, input logic [6:0] exp, input string nm);
    vec_t v;
    v = '{r: r, rs: rs, rt: rt, exRd: exRd, exRt: eRt, br: br, icm: icm, icr: icr,
          dcm: dcm, dcr: dcr, exp: exp};
    stimQ.push_back(v);
    stimNameQ.push_back(nm);
  endtask

  // Control-only shorthand: no register hazard fields.
  task automatic addCtl(input logic br, input logic icm, input logic icr, input logic dcm,
                        input logic dcr, input logic [6:0] exp, input string nm);
    addVec(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, br, icm, icr, dcm, dcr, exp, nm);
  endtask

  task automatic applyStimulus(input vec_t v, input string nm);
    @(posedge clk);
    #1;
    rst       = v.r;
    idRs      = v.rs;
    idRt      = v.rt;
    exMemRead = v.exRd;
    exRt      = v.exRt;
    brTaken   = v.br;
    icMiss    = v.icm;
    icReady   = v.icr;
    dcMiss    = v.dcm;
    dcReady   = v.dcr;
    expQ.push_back(v.exp);
    nameQ.push_back(nm);
    if (!v.r) begin
      if (!v.exp[6]) expStall++;
      if (v.exp[4])  expFlush++;
    end
  endtask

  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      logic [6:0] e;
      string n;
      e = expQ.pop_front();
      n = nameQ.pop_front();
      checkOutput(n, {25'd0, pcWe, ifIdWe, ifIdZero, idExZero, exMemWe, memWbWe, err}, {25'd0, e});
    end
  end

  initial begin
    for (int i = 0; i < 10; i++) addVec(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 0, 0, 0, 0, 0, RST, "reset_hold");

    addCtl(0, 0, 0, 0, 0, NORM, "run_idle");
    addCtl(0, 0, 1, 0, 1, NORM, "run_stray_ready");

    addVec(1'b0, 5'd5, 5'd0, 1'b1, 5'd5, 0, 0, 0, 0, 0, LU, "loaduse_rs");
    addCtl(0, 0, 0, 0, 0, NORM, "after_loaduse");
    addVec(1'b0, 5'd3, 5'd7, 1'b1, 5'd7, 0, 0, 0, 0, 0, LU, "loaduse_rt");
    addVec(1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 0, 0, 0, 0, 0, NORM, "load_r0_nohazard");
    addVec(1'b0, 5'd5, 5'd5, 1'b0, 5'd5, 0, 0, 0, 0, 0, NORM, "nonload_match");
    addVec(1'b0, 5'd4, 5'd6, 1'b1, 5'd5, 0, 0, 0, 0, 0, NORM, "load_nomatch");

    addCtl(1, 0, 0, 0, 0, BR, "branch_flush");
    addCtl(0, 0, 0, 0, 0, NORM, "after_branch");
    addVec(1'b0, 5'd9, 5'd0, 1'b1, 5'd9, 1, 0, 0, 0, 0, LU, "branch_vs_loaduse");

    addCtl(0, 1, 0, 0, 0, IMISS, "imiss_run");
    addCtl(0, 1, 0, 0, 0, IMISS, "iwait_1");
    addCtl(0, 1, 0, 0, 1, IMISS, "iwait_stray_dcready");
    addVec(1'b0, 5'd8, 5'd0, 1'b1, 5'd8, 0, 1, 0, 0, 0, IWLU, "iwait_loaduse");
    addCtl(0, 1, 0, 0, 0, IMISS, "iwait_4");
    addCtl(0, 0, 1, 0, 0, IMISS, "iwait_icready");
    addCtl(0, 0, 0, 0, 0, NORM, "run_after_ifill");

    addCtl(0, 1, 0, 0, 0, IMISS, "imiss_then_dmiss");
    addCtl(0, 1, 0, 0, 0, IMISS, "iwait_a");
    addCtl(0, 1, 0, 1, 0, IMISS, "iwait_dcmiss");
    addCtl(0, 1, 0, 1, 0, FRZ, "dwait_freeze");
    addCtl(0, 1, 0, 0, 1, FRZ, "dwait_dcready_pend");
    addCtl(0, 1, 0, 0, 0, IMISS, "back_to_iwait");
    addCtl(0, 0, 1, 0, 0, IMISS, "iwait_icready2");
    addCtl(0, 0, 0, 0, 0, NORM, "run_after_both");

    addCtl(0, 1, 0, 0, 0, IMISS, "imiss_b");
    addCtl(0, 1, 0, 1, 0, IMISS, "iwait_dcmiss_b");
    addCtl(0, 0, 1, 1, 0, FRZ, "dwait_icready_clr");
    addCtl(0, 0, 0, 0, 1, FRZ, "dwait_dcready_nopend");
    addCtl(0, 0, 0, 0, 0, NORM, "run_after_clr");

    addCtl(0, 1, 0, 0, 0, IMISS, "imiss_c");
    addCtl(0, 0, 1, 1, 0, IMISS, "iwait_both_ready_miss");
    addCtl(0, 0, 0, 1, 1, FRZ, "dwait_c_dcready");
    addCtl(0, 0, 0, 0, 0, NORM, "run_after_c");

    addCtl(0, 1, 0, 1, 0, FRZ, "run_dmiss_with_imiss");
    addCtl(0, 1, 0, 0, 1, FRZ, "dwait_d_dcready");
    addCtl(0, 0, 1, 0, 0, IMISS, "iwait_d_icready");
    addCtl(0, 0, 0, 0, 0, NORM, "run_after_d");

    for (int i = 0; i < 256; i++) addCtl(0, 0, 0, 1, 0, FRZ, "dmiss_until_timeout");
    addCtl(0, 0, 0, 0, 0, NORM | ERR, "run_after_timeout");
    addCtl(1, 0, 0, 0, 0, BR | ERR, "err_sticky_branch");
    addVec(1'b0, 5'd2, 5'd0, 1'b1, 5'd2, 0, 0, 0, 0, 0, LU | ERR, "err_sticky_loaduse");

    while (stimQ.size() > 0) applyStimulus(stimQ.pop_front(), stimNameQ.pop_front());

    @(posedge clk);
    #1;
`ifdef STALL_CNT_EN
    checkOutput("stall_cyc", stallCyc, expStall);
    checkOutput("flush_cnt", flushCnt, expFlush);
`else
    checkOutput("stall_cyc_tied", stallCyc, 32'd0);
    checkOutput("flush_cnt_tied", flushCnt, 32'd0);
`endif

    for (int i = 0; i < 5 && expQ.size() > 0; i++) @(posedge clk);
    if (expQ.size() > 0) begin
      vecCount++;
      missCount++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, required 0", expQ.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end
endmodule
